soc_obi_apb_arbiter: RTL and testbench

- Shares the single 32-bit SoC APB segment among NumReq 64-bit OBI managers: round-robin arbitration, one transaction in flight, APB setup/access sequencing, and width/range checks.
- Sits between the OBI crossbar leaves and the peripheral APB demux.
- Uses soc_bus_pkg types for all bus ports.

---
 rtl/soc_obi_apb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_soc_obi_apb_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_obi_apb_arbiter.sv
// rtl/soc_obi_apb_arbiter.sv - round-robin OBI-to-APB arbiter for the shared 32-bit SoC APB segment
// One transaction in flight; 64-bit OBI accesses are narrowed to one 32-bit APB lane.

package soc_bus_pkg;
  typedef struct packed {
    logic [47:0] addr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [3:0]  aid;
  } soc_obi_a_t;

  typedef struct packed {
    logic       req;
    soc_obi_a_t a;
  } soc_obi_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } soc_obi_r_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    soc_obi_r_t r;
  } soc_obi_rsp_t;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } soc_apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } soc_apb_resp_t;
endpackage

module soc_obi_apb_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  soc_obi_req_t  obi_req_i [NumReq],
  output soc_obi_rsp_t  obi_rsp_o [NumReq],
  output soc_apb_req_t  apb_req_o,
  input  soc_apb_resp_t apb_rsp_i,
  output logic          busy_o,
  output logic          timeout_o
);
  localparam int unsigned     IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [31:0]     ToLast   = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);
  localparam logic [IdxW-1:0] LastInit = IdxW'(NumReq - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR, RESP} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] last_q, sel_q, win;
  logic            found, chk_fail, hi, to_hit;
  int unsigned     cand;
  soc_obi_a_t      a_q;
  logic [31:0]     rdata_q, cnt_q;
  logic            err_q, timeout_q;

  // Search starts just after the previous winner, wrapping, so priority rotates.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = 0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!found && obi_req_i[IdxW'(cand)].req) begin
        found = 1'b1;
        win   = IdxW'(cand);
      end
    end
  end

  assign chk_fail = (obi_req_i[win].a.addr[47:32] != 16'd0) ||
                    ((obi_req_i[win].a.be[7:4] != 4'd0) && (obi_req_i[win].a.be[3:0] != 4'd0));
  assign hi       = (a_q.be[7:4] != 4'd0) || ((a_q.be == 8'd0) && a_q.addr[2]);
  assign to_hit   = (TimeoutCycles != 0) && (cnt_q == ToLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = chk_fail ? ERR : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb_rsp_i.pready || to_hit) state_d = RESP;
      ERR:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    apb_req_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) obi_rsp_o[i] = '0;
    if (state_q == IDLE && found) obi_rsp_o[win].gnt = 1'b1;
    if (state_q == SETUP || state_q == ACCESS) begin
      apb_req_o.psel    = 1'b1;
      apb_req_o.penable = (state_q == ACCESS);
      apb_req_o.paddr   = a_q.addr[31:0];
      apb_req_o.pwrite  = a_q.we;
      if (a_q.we) begin
        apb_req_o.pwdata = hi ? a_q.wdata[63:32] : a_q.wdata[31:0];
        apb_req_o.pstrb  = hi ? a_q.be[7:4] : a_q.be[3:0];
      end
    end
    if (state_q == RESP) begin
      obi_rsp_o[sel_q].rvalid  = 1'b1;
      obi_rsp_o[sel_q].r.rdata = {rdata_q, rdata_q};
      obi_rsp_o[sel_q].r.rid   = a_q.aid;
      obi_rsp_o[sel_q].r.err   = err_q;
    end
  end

  // rdata_q is forced to zero for writes and errors so RESP can replicate it unconditionally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q    <= LastInit;
      sel_q     <= '0;
      a_q       <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (found) begin
          sel_q  <= win;
          last_q <= win;
          a_q    <= obi_req_i[win].a;
        end
        SETUP: cnt_q <= '0;
        ACCESS: begin
          if (apb_rsp_i.pready) begin
            rdata_q <= (a_q.we || apb_rsp_i.pslverr) ? 32'd0 : apb_rsp_i.prdata;
            err_q   <= apb_rsp_i.pslverr;
          end else if (to_hit) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ERR: begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_soc_obi_apb_arbiter.sv
// tb/tb_soc_obi_apb_arbiter.sv - directed self-checking bench for soc_obi_apb_arbiter
module tb_soc_obi_apb_arbiter;
  import soc_bus_pkg::*;
  localparam int N = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  soc_obi_req_t  obi_req_i [N];
  soc_obi_rsp_t  obi_rsp_o [N];
  soc_apb_req_t  apb_req_o;
  soc_apb_resp_t apb_rsp_i;
  logic          busy_o, timeout_o;
  logic [N-1:0]  gnt_v, rvalid_v;
  int            checks = 0;
  int            errors = 0;

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < N; g++) begin : g_v
    assign gnt_v[g]    = obi_rsp_o[g].gnt;
    assign rvalid_v[g] = obi_rsp_o[g].rvalid;
  end

  soc_obi_apb_arbiter #(.NumReq(N), .TimeoutCycles(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .obi_req_i(obi_req_i), .obi_rsp_o(obi_rsp_o),
    .apb_req_o(apb_req_o), .apb_rsp_i(apb_rsp_i), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) obi_req_i[i] = '0;
  endtask

  task automatic set_req(input int i, input logic [47:0] addr, input logic we,
                         input logic [7:0] be, input logic [63:0] wdata, input logic [3:0] aid);
    obi_req_i[i].req     = 1'b1;
    obi_req_i[i].a.addr  = addr;
    obi_req_i[i].a.we    = we;
    obi_req_i[i].a.be    = be;
    obi_req_i[i].a.wdata = wdata;
    obi_req_i[i].a.aid   = aid;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_reqs();
    apb_rsp_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_reqs();
    apb_rsp_i = '0;
    step();
    mid();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    checks++; if (apb_req_o !== '0) begin errors++; $display("FAIL rst_apb got %h exp 0", apb_req_o); end
    checks++; if ({gnt_v, rvalid_v, timeout_o} !== 9'd0) begin errors++; $display("FAIL rst_rsp got %b exp 0", {gnt_v, rvalid_v, timeout_o}); end
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_write();
    step();
    set_req(0, 48'h0000_1000_0008, 1'b1, 8'hF0, 64'hDEAD_BEEF_0000_0000, 4'h3);
    apb_rsp_i = '0;
    apb_rsp_i.pready = 1'b1;
    mid();
    checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL wr_gnt got %b exp 0001", gnt_v); end
    step(); clear_reqs(); mid();
    checks++; if ({apb_req_o.psel, apb_req_o.penable, apb_req_o.pwrite} !== 3'b101) begin errors++; $display("FAIL wr_setup_ctl got %b exp 101", {apb_req_o.psel, apb_req_o.penable, apb_req_o.pwrite}); end
    checks++; if (apb_req_o.paddr !== 32'h1000_0008) begin errors++; $display("FAIL wr_paddr got %h exp 10000008", apb_req_o.paddr); end
    checks++; if (apb_req_o.pwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_pwdata got %h exp deadbeef", apb_req_o.pwdata); end
    checks++; if (apb_req_o.pstrb !== 4'hF) begin errors++; $display("FAIL wr_pstrb got %h exp f", apb_req_o.pstrb); end
    step(); mid();
    checks++; if ({apb_req_o.psel, apb_req_o.penable, rvalid_v} !== 6'b110000) begin errors++; $display("FAIL wr_access got %b exp 110000", {apb_req_o.psel, apb_req_o.penable, rvalid_v}); end
    step(); mid();
    checks++; if (rvalid_v !== 4'b0001) begin errors++; $display("FAIL wr_rvalid got %b exp 0001", rvalid_v); end
    checks++; if ({obi_rsp_o[0].r.err, obi_rsp_o[0].r.rid} !== 5'b0_0011) begin errors++; $display("FAIL wr_resp got %b exp 00011", {obi_rsp_o[0].r.err, obi_rsp_o[0].r.rid}); end
    step(); mid();
    checks++; if ({rvalid_v, busy_o} !== 5'd0) begin errors++; $display("FAIL wr_done got %b exp 0", {rvalid_v, busy_o}); end
  endtask

  task automatic test_read_wait();
    step();
    set_req(0, 48'h0000_2000_0004, 1'b0, 8'h0F, 64'h0, 4'hA);
    apb_rsp_i = '0;
    apb_rsp_i.prdata = 32'h1234_5678;
    mid();
    checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL rd_gnt got %b exp 0001", gnt_v); end
    step(); clear_reqs(); mid();
    checks++; if ({apb_req_o.pwrite, apb_req_o.pwdata, apb_req_o.pstrb} !== 37'd0) begin errors++; $display("FAIL rd_setup got %h exp 0", {apb_req_o.pwrite, apb_req_o.pwdata, apb_req_o.pstrb}); end
    step(); mid();
    step(); mid();
    step(); apb_rsp_i.pready = 1'b1; mid();
    checks++; if (rvalid_v !== 4'b0000) begin errors++; $display("FAIL rd_early got %b exp 0000", rvalid_v); end
    step(); apb_rsp_i.pready = 1'b0; mid();
    checks++; if (rvalid_v !== 4'b0001) begin errors++; $display("FAIL rd_rvalid got %b exp 0001", rvalid_v); end
    checks++; if (obi_rsp_o[0].r.rdata !== 64'h1234_5678_1234_5678) begin errors++; $display("FAIL rd_rdata got %h exp 1234567812345678", obi_rsp_o[0].r.rdata); end
    checks++; if ({obi_rsp_o[0].r.err, obi_rsp_o[0].r.rid} !== 5'b0_1010) begin errors++; $display("FAIL rd_rid_err got %b exp 01010", {obi_rsp_o[0].r.err, obi_rsp_o[0].r.rid}); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg, ev;
    do_reset();
    apb_rsp_i.pready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 48'h0000_0000_0100, 1'b1, 8'h0F, 64'h5, 4'(i));
    for (int c = 0; c < 20; c++) begin
      mid();
      eg = (c % 4 == 0) ? 4'(1 << ((c / 4) % 4)) : 4'b0;
      ev = (c % 4 == 3) ? 4'(1 << ((c / 4) % 4)) : 4'b0;
      checks++; if (gnt_v !== eg) begin errors++; $display("FAIL rr_gnt c%0d got %b exp %b", c, gnt_v, eg); end
      checks++; if (rvalid_v !== ev) begin errors++; $display("FAIL rr_rvalid c%0d got %b exp %b", c, rvalid_v, ev); end
      step();
    end
    clear_reqs();
    apb_rsp_i = '0;
  endtask

  task automatic test_errors();
    logic [47:0] addr [2];
    logic [7:0]  be [2];
    addr[0] = 48'h1_0000_0000; be[0] = 8'h0F;
    addr[1] = 48'h0000_0000_0200; be[1] = 8'h18;
    for (int v = 0; v < 2; v++) begin
      step();
      set_req(0, addr[v], 1'(v), be[v], 64'hFFFF_FFFF_FFFF_FFFF, 4'(v + 1));
      apb_rsp_i = '0;
      apb_rsp_i.pready = 1'b1;
      apb_rsp_i.prdata = 32'hAAAA_5555;
      mid();
      checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL err%0d_gnt got %b exp 0001", v, gnt_v); end
      for (int c = 0; c < 4; c++) begin
        if (c > 0) begin step(); clear_reqs(); mid(); end
        checks++; if (apb_req_o.psel !== 1'b0) begin errors++; $display("FAIL err%0d_psel c%0d got 1 exp 0", v, c); end
        if (c == 2) begin
          checks++; if (rvalid_v !== 4'b0001) begin errors++; $display("FAIL err%0d_rvalid got %b exp 0001", v, rvalid_v); end
          checks++; if ({obi_rsp_o[0].r.err, obi_rsp_o[0].r.rdata} !== {1'b1, 64'd0}) begin errors++; $display("FAIL err%0d_resp got %h exp 1_0", v, {obi_rsp_o[0].r.err, obi_rsp_o[0].r.rdata}); end
        end
      end
    end
    apb_rsp_i = '0;
  endtask

  task automatic test_timeout();
    step();
    set_req(0, 48'h0000_3000_0000, 1'b0, 8'h0F, 64'h0, 4'h6);
    apb_rsp_i = '0;
    mid();
    checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL to_gnt got %b exp 0001", gnt_v); end
    for (int c = 1; c <= 11; c++) begin
      step(); clear_reqs(); mid();
      checks++; if (apb_req_o.psel !== (c <= 9)) begin errors++; $display("FAIL to_psel c%0d got %b exp %b", c, apb_req_o.psel, (c <= 9)); end
      checks++; if (timeout_o !== (c == 10)) begin errors++; $display("FAIL to_pulse c%0d got %b exp %b", c, timeout_o, (c == 10)); end
      checks++; if (rvalid_v[0] !== (c == 10)) begin errors++; $display("FAIL to_rvalid c%0d got %b exp %b", c, rvalid_v[0], (c == 10)); end
      if (c == 10) begin
        checks++; if (obi_rsp_o[0].r.err !== 1'b1) begin errors++; $display("FAIL to_err got 0 exp 1"); end
      end
    end
  endtask

  task automatic test_slverr();
    step();
    set_req(0, 48'h0000_0000_0040, 1'b1, 8'h0F, 64'h1, 4'h9);
    apb_rsp_i = '0;
    apb_rsp_i.pready  = 1'b1;
    apb_rsp_i.pslverr = 1'b1;
    mid();
    step(); clear_reqs(); mid();
    step(); mid();
    step(); mid();
    checks++; if (rvalid_v !== 4'b0001) begin errors++; $display("FAIL slv_rvalid got %b exp 0001", rvalid_v); end
    checks++; if ({obi_rsp_o[0].r.err, obi_rsp_o[0].r.rid} !== 5'b1_1001) begin errors++; $display("FAIL slv_resp got %b exp 11001", {obi_rsp_o[0].r.err, obi_rsp_o[0].r.rid}); end
    apb_rsp_i = '0;
  endtask

  task automatic test_reset_mid();
    step();
    set_req(0, 48'h0000_4000_0000, 1'b0, 8'h0F, 64'h0, 4'h7);
    apb_rsp_i = '0;
    mid();
    step(); clear_reqs(); mid();
    step(); mid();
    checks++; if (apb_req_o.penable !== 1'b1) begin errors++; $display("FAIL rm_access got 0 exp 1"); end
    #1 rst_ni = 1'b0;
    #1;
    checks++; if ({apb_req_o.psel, apb_req_o.penable, busy_o, rvalid_v} !== 7'd0) begin errors++; $display("FAIL rm_async got %b exp 0", {apb_req_o.psel, apb_req_o.penable, busy_o, rvalid_v}); end
    step(); step();
    rst_ni = 1'b1;
    set_req(0, 48'h0000_0000_0010, 1'b0, 8'h0F, 64'h0, 4'h1);
    set_req(1, 48'h0000_0000_0020, 1'b0, 8'h0F, 64'h0, 4'h2);
    mid();
    checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL rm_first_gnt got %b exp 0001", gnt_v); end
    step(); clear_reqs();
    apb_rsp_i.pready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    clear_reqs();
    apb_rsp_i = '0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_round_robin();
    test_errors();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
